// File: rtl/beat_counter_pkg.sv
// Shared definitions for the 2-D frame beat counter: FSM encoding and a parameter legality check.
package beat_counter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic bit params_legal(
        input int unsigned pix_w,
        input int unsigned line_w,
        input int unsigned ppl,
        input int unsigned lines,
        input int unsigned min_pix,
        input int unsigned max_pix
    );
        longint unsigned pix_span;
        longint unsigned line_span;
        pix_span  = 64'(1) << pix_w;
        line_span = 64'(1) << line_w;
        return (min_pix <= max_pix) && (max_pix < ppl) && (64'(ppl) <= pix_span) &&
               (lines >= 1) && (64'(lines) <= line_span);
    endfunction

endpackage

// File: rtl/beat_wrap_counter.sv
// Up-counter that wraps to zero after reaching WRAP; also exposes its next-state value.
module beat_wrap_counter #(
    parameter int unsigned W    = 8,
    parameter int unsigned WRAP = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt,
    output logic         at_wrap
);

    localparam logic [W-1:0] WrapVal = W'(WRAP);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_wrap = (count_q == WrapVal);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = at_wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign count_nxt = count_d;

endmodule

// File: rtl/frame_beat_counter.sv
// Pixel/line beat generator for the detector pipeline: run FSM, processing window and
// line/frame markers, all registered and aligned to the counter values.
module frame_beat_counter
    import beat_counter_pkg::*;
#(
    parameter int unsigned PIX_W           = 20,
    parameter int unsigned LINE_W          = 12,
    parameter int unsigned PIXELS_PER_LINE = 160,
    parameter int unsigned LINES           = 120,
    parameter int unsigned MINPIXEL        = 4,
    parameter int unsigned MAXPIXEL        = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              startCounterEn,
    input  logic              continuous,
    input  logic              stall,
    input  logic              abort,
    output logic              started,
    output logic              process,
    output logic [PIX_W-1:0]  pixelCounter,
    output logic [LINE_W-1:0] lineCounter,
    output logic              lineEnd,
    output logic              frameEnd,
    output logic              done
);

    if (!params_legal(PIX_W, LINE_W, PIXELS_PER_LINE, LINES, MINPIXEL, MAXPIXEL)) begin : g_bad_params
        $error("frame_beat_counter: illegal parameter combination");
    end

    localparam logic [PIX_W-1:0]  PixMin   = PIX_W'(MINPIXEL);
    localparam logic [PIX_W-1:0]  PixMax   = PIX_W'(MAXPIXEL);
    localparam logic [PIX_W-1:0]  PixLast  = PIX_W'(PIXELS_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LineLast = LINE_W'(LINES - 1);

    state_e state_q, state_d;

    logic              pix_en, pix_clr, pix_wrap;
    logic              line_en, line_wrap;
    logic [PIX_W-1:0]  pix_nxt;
    logic [LINE_W-1:0] line_nxt;

    logic live_d;
    logic started_d, process_d, line_end_d, frame_end_d, done_d;
    logic started_q, process_q, line_end_q, frame_end_q, done_q;

    // Counters only move on a live RUN beat; anything leaving RUN returns them to zero.
    assign pix_en  = (state_q == StRun) && !stall && !abort;
    assign pix_clr = (state_d != StRun);
    assign line_en = pix_en && pix_wrap;

    beat_wrap_counter #(
        .W    (PIX_W),
        .WRAP (PIXELS_PER_LINE - 1)
    ) u_pix_cnt (
        .clk       (clk),
        .reset     (reset),
        .en        (pix_en),
        .clr       (pix_clr),
        .count     (pixelCounter),
        .count_nxt (pix_nxt),
        .at_wrap   (pix_wrap)
    );

    beat_wrap_counter #(
        .W    (LINE_W),
        .WRAP (LINES - 1)
    ) u_line_cnt (
        .clk       (clk),
        .reset     (reset),
        .en        (line_en),
        .clr       (pix_clr),
        .count     (lineCounter),
        .count_nxt (line_nxt),
        .at_wrap   (line_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            started_q   <= 1'b0;
            process_q   <= 1'b0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            process_q   <= process_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!abort && startCounterEn) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (!stall && pix_wrap && line_wrap) begin
                    state_d = continuous ? StRun : StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A stalled beat re-shows the held indices with all markers masked, so each index
    // raises its markers exactly once: on the first non-stalled cycle it is shown.
    always_comb begin
        live_d      = (state_d == StRun) && !stall;
        started_d   = (state_d == StRun);
        done_d      = (state_d == StDone);
        process_d   = live_d && (pix_nxt >= PixMin) && (pix_nxt <= PixMax);
        line_end_d  = live_d && (pix_nxt == PixLast);
        frame_end_d = line_end_d && (line_nxt == LineLast);
    end

    assign started  = started_q;
    assign process  = process_q;
    assign lineEnd  = line_end_q;
    assign frameEnd = frame_end_q;
    assign done     = done_q;

endmodule

// File: tb/tb_frame_beat_counter.sv
// Directed bench for frame_beat_counter with an 8x3 frame and a 2..5 processing window.
module tb_frame_beat_counter;

    localparam int PPL    = 8;
    localparam int LINES  = 3;
    localparam int MINP   = 2;
    localparam int MAXP   = 5;
    localparam int PIX_W  = 20;
    localparam int LINE_W = 12;
    localparam int NV     = 13;

    logic              clk = 1'b0;
    logic              reset, start_s, cont_s, stall_s, abort_s;
    logic              started_s, proc_s, line_end_s, frame_end_s, done_s;
    logic [PIX_W-1:0]  pix_s;
    logic [LINE_W-1:0] line_s;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit rst, start, cont, stall, abort;
        int st, pr, pix, line, le, fe, dn;
    } vec_t;

    vec_t tbl[NV];

    frame_beat_counter #(
        .PIX_W           (PIX_W),
        .LINE_W          (LINE_W),
        .PIXELS_PER_LINE (PPL),
        .LINES           (LINES),
        .MINPIXEL        (MINP),
        .MAXPIXEL        (MAXP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .startCounterEn (start_s),
        .continuous     (cont_s),
        .stall          (stall_s),
        .abort          (abort_s),
        .started        (started_s),
        .process        (proc_s),
        .pixelCounter   (pix_s),
        .lineCounter    (line_s),
        .lineEnd        (line_end_s),
        .frameEnd       (frame_end_s),
        .done           (done_s)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected summary before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int st, input int pr, input int pix,
                       input int line, input int le, input int fe, input int dn);
        cmp({tag, " started"}, int'(started_s), st);
        cmp({tag, " process"}, int'(proc_s), pr);
        cmp({tag, " pixelCounter"}, int'(pix_s), pix);
        cmp({tag, " lineCounter"}, int'(line_s), line);
        cmp({tag, " lineEnd"}, int'(line_end_s), le);
        cmp({tag, " frameEnd"}, int'(frame_end_s), fe);
        cmp({tag, " done"}, int'(done_s), dn);
    endtask

    task automatic chk_beat(input string tag, input int pix, input int line);
        int pr, le, fe;
        pr = (pix >= MINP && pix <= MAXP) ? 1 : 0;
        le = (pix == PPL - 1) ? 1 : 0;
        fe = (pix == PPL - 1 && line == LINES - 1) ? 1 : 0;
        chk(tag, 1, pr, pix, line, le, fe, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_done(input string tag);
        chk(tag, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic pulse_start();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
    endtask

    initial begin
        int fe_cnt;
        int k;

        //          rst   start cont  stall abort  st pr pix ln le fe dn
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,  0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  1, 0, 1, 0, 0, 0, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1, 0, 1, 0, 0, 0, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1, 2, 0, 0, 0, 0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 0, 0, 0, 0, 0};

        reset = 1'b1; start_s = 1'b0; cont_s = 1'b0; stall_s = 1'b0; abort_s = 1'b0;

        for (int r = 0; r < NV; r++) begin
            reset   = tbl[r].rst;
            start_s = tbl[r].start;
            cont_s  = tbl[r].cont;
            stall_s = tbl[r].stall;
            abort_s = tbl[r].abort;
            step();
            chk($sformatf("vec%0d", r), tbl[r].st, tbl[r].pr, tbl[r].pix, tbl[r].line,
                tbl[r].le, tbl[r].fe, tbl[r].dn);
        end
        reset = 1'b0; start_s = 1'b0; cont_s = 1'b0; stall_s = 1'b0; abort_s = 1'b0;

        // One-shot frame.
        pulse_start();
        for (int i = 0; i < PPL * LINES; i++) begin
            chk_beat($sformatf("t1 beat%0d", i), i % PPL, i / PPL);
            step();
        end
        chk_done("t1 done");
        step();
        chk_idle("t1 idle");

        // Continuous, cleared in the middle of frame 2.
        cont_s = 1'b1;
        pulse_start();
        for (int i = 0; i < 2 * PPL * LINES; i++) begin
            k = i % (PPL * LINES);
            chk_beat($sformatf("t2 beat%0d", i), k % PPL, k / PPL);
            if (i == 28) cont_s = 1'b0;
            step();
        end
        chk_done("t2 done");
        step();
        chk_idle("t2 idle");

        // Stall three cycles while pixel 4 is shown.
        pulse_start();
        for (int i = 0; i <= 4; i++) begin
            chk_beat($sformatf("t3 beat%0d", i), i, 0);
            if (i < 4) step();
        end
        stall_s = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("t3 stall%0d", s), 1, 0, 4, 0, 0, 0, 0);
        end
        stall_s = 1'b0;
        step();
        chk_beat("t3 resume", 5, 0);
        abort_s = 1'b1;
        step();
        chk_idle("t3 abort");
        abort_s = 1'b0;
        step();
        chk_idle("t3 post");

        // Stall across the last beat: frameEnd appears on release, exactly once.
        pulse_start();
        for (int i = 0; i <= 22; i++) begin
            chk_beat($sformatf("t4 beat%0d", i), i % PPL, i / PPL);
            if (i < 22) step();
        end
        fe_cnt = 0;
        stall_s = 1'b1;
        for (int s = 0; s < 2; s++) begin
            step();
            fe_cnt += int'(frame_end_s);
            chk($sformatf("t4 hold6 %0d", s), 1, 0, 6, 2, 0, 0, 0);
        end
        stall_s = 1'b0;
        step();
        fe_cnt += int'(frame_end_s);
        chk_beat("t4 release", 7, 2);
        stall_s = 1'b1;
        for (int s = 0; s < 2; s++) begin
            step();
            fe_cnt += int'(frame_end_s);
            chk($sformatf("t4 hold7 %0d", s), 1, 0, 7, 2, 0, 0, 0);
        end
        stall_s = 1'b0;
        step();
        fe_cnt += int'(frame_end_s);
        chk_done("t4 done");
        cmp("t4 frameEnd pulses", fe_cnt, 1);
        step();
        chk_idle("t4 idle");

        // Abort at (3,1); start held during RUN must be ignored.
        pulse_start();
        for (int i = 0; i <= 11; i++) begin
            chk_beat($sformatf("t5 beat%0d", i), i % PPL, i / PPL);
            if (i == 5) start_s = 1'b1;
            if (i == 8) start_s = 1'b0;
            if (i < 11) step();
        end
        abort_s = 1'b1;
        step();
        chk_idle("t5 abort");
        abort_s = 1'b0;
        step();
        chk_idle("t5 post");

        // Reset at (5,1), then abort+start together in IDLE.
        pulse_start();
        for (int i = 0; i <= 13; i++) begin
            chk_beat($sformatf("t6 beat%0d", i), i % PPL, i / PPL);
            if (i < 13) step();
        end
        reset = 1'b1;
        step();
        chk_idle("t6 reset");
        reset = 1'b0;
        abort_s = 1'b1;
        start_s = 1'b1;
        step();
        chk_idle("t6 abort+start");
        abort_s = 1'b0;
        start_s = 1'b0;
        step();
        chk_idle("t6 post");

        // Start held high: a new frame follows DONE -> IDLE.
        start_s = 1'b1;
        step();
        for (int i = 0; i < PPL * LINES; i++) begin
            chk_beat($sformatf("t7 beat%0d", i), i % PPL, i / PPL);
            step();
        end
        chk_done("t7 done");
        step();
        chk_idle("t7 idle");
        step();
        chk_beat("t7 restart", 0, 0);
        start_s = 1'b0;
        step();
        chk_beat("t7 next", 1, 0);
        abort_s = 1'b1;
        step();
        chk_idle("t7 abort");
        abort_s = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
